alu_md: RTL and testbench

ALU_MD -- requirements
Module: alu_md

---
 rtl/alu_md.sv | 160 ++++++++++++++++
 tb/tb_alu_md.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_md.sv
// ALU with iterative multiply/divide: single-cycle ops and fast-path cases finish in one
// cycle, MUL/MULHU/DIV[U]/REM[U] take WIDTH shift steps plus one sign-fixup cycle.
module alu_md #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam logic [3:0] LAND  = 4'b0000, LOR  = 4'b0001, ADD  = 4'b0010, MUL  = 4'b0011;
  localparam logic [3:0] MULHU = 4'b0100, DIVU = 4'b0101, SUB  = 4'b0110, LESS = 4'b0111;
  localparam logic [3:0] LSHR  = 4'b1000, LSHL = 4'b1001, ASHR = 4'b1010, REMU = 4'b1011;
  localparam logic [3:0] DIV   = 4'b1100, LXOR = 4'b1101, REM  = 4'b1110;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL1    = {WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [SHW:0]     cnt;
  logic [WIDTH-1:0] acc, mq, opnd;
  logic [3:0]       op_q;
  logic             neg_q, neg_r;

  logic             accept, is_div, is_iter, sgn_op, div_zero, sgn_ovf, fast, go_busy;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] single_res, fast_res, imm_res, fix_res, acc_n, mq_n;
  logic [WIDTH-1:0] abs1, abs2;
  logic [WIDTH:0]   sum, rem_sh, diff;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = go_busy ? BUSY : DONE;
      BUSY:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Opcode decode and the single-cycle / fast-path result
  always_comb begin
    shamt    = op2[SHW-1:0];
    is_div   = (alu_op == DIVU) || (alu_op == REMU) || (alu_op == DIV) || (alu_op == REM);
    is_iter  = is_div || (alu_op == MUL) || (alu_op == MULHU);
    sgn_op   = (alu_op == DIV) || (alu_op == REM);
    div_zero = (op2 == '0);
    sgn_ovf  = sgn_op && (op1 == MIN_NEG) && (op2 == ALL1);
    fast     = is_div && (div_zero || sgn_ovf);
    go_busy  = is_iter && !fast;
    abs1     = (sgn_op && op1[WIDTH-1]) ? -op1 : op1;
    abs2     = (sgn_op && op2[WIDTH-1]) ? -op2 : op2;

    case (alu_op)
      LAND:    single_res = op1 & op2;
      LOR:     single_res = op1 | op2;
      LXOR:    single_res = op1 ^ op2;
      ADD:     single_res = op1 + op2;
      SUB:     single_res = op1 - op2;
      LESS:    single_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      LSHR:    single_res = op1 >> shamt;
      LSHL:    single_res = op1 << shamt;
      ASHR:    single_res = $unsigned($signed(op1) >>> shamt);
      default: single_res = '0;
    endcase

    fast_res = '0;
    if (div_zero) fast_res = ((alu_op == DIVU) || (alu_op == DIV)) ? ALL1 : op1;
    else if (alu_op == DIV) fast_res = op1;
    imm_res = fast ? fast_res : single_res;
  end

  // One iteration: shift-add for multiply, restoring subtract for divide
  always_comb begin
    sum    = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
    rem_sh = {acc, mq[WIDTH-1]};
    diff   = rem_sh - {1'b0, opnd};
    if ((op_q == MUL) || (op_q == MULHU)) begin
      acc_n = sum[WIDTH:1];
      mq_n  = {sum[0], mq[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      acc_n = diff[WIDTH-1:0];
      mq_n  = {mq[WIDTH-2:0], 1'b1};
    end else begin
      acc_n = rem_sh[WIDTH-1:0];
      mq_n  = {mq[WIDTH-2:0], 1'b0};
    end

    case (op_q)
      MUL:     fix_res = mq;
      MULHU:   fix_res = acc;
      DIVU:    fix_res = mq;
      REMU:    fix_res = acc;
      DIV:     fix_res = neg_q ? -mq : mq;
      REM:     fix_res = neg_r ? -acc : acc;
      default: fix_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      mq     <= '0;
      opnd   <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
      zero   <= 1'b1;
    end else if (!flush) begin
      if (accept) begin
        if (go_busy) begin
          op_q  <= alu_op;
          cnt   <= (SHW+1)'(WIDTH);
          acc   <= '0;
          mq    <= is_div ? abs1 : op2;
          opnd  <= is_div ? abs2 : op1;
          neg_q <= sgn_op && (op1[WIDTH-1] ^ op2[WIDTH-1]);
          neg_r <= sgn_op && op1[WIDTH-1];
        end else begin
          result <= imm_res;
          zero   <= (imm_res == '0);
        end
      end else if (state == BUSY) begin
        if (cnt != '0) begin
          acc <= acc_n;
          mq  <= mq_n;
          cnt <= cnt - (SHW+1)'(1);
        end else begin
          result <= fix_res;
          zero   <= (fix_res == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// Directed self-checking bench for alu_md (WIDTH=32) with hand-computed vectors.
module tb_alu_md;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, zero;
  logic [31:0] op1, op2, result;
  logic [3:0]  alu_op;

  int checks = 0;
  int failures = 0;

  logic [31:0] res;
  logic        zr;
  int          lat;
  int          seen;

  alu_md #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble operands after acceptance, count edges until out_valid.
  // With drain=1 one more edge is taken so the block is back in IDLE.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit drain, output logic [31:0] r, output logic z, output int l);
    @(negedge clk);
    op1 = a; op2 = b; alu_op = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op1 = ~a; op2 = a ^ b; alu_op = 4'b0010;
    l = 0;
    while (!out_valid && l < 100) begin
      @(posedge clk); #1;
      l++;
    end
    r = result; z = zero;
    if (drain) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op1 = '0; op2 = '0; alu_op = '0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    @(negedge clk); rst_n = 1'b1;

    // ADD wrap to zero, latency 1, back to IDLE the cycle after
    run_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 1'b0, res, zr, lat);
    check("add_res", res, 32'd0);
    check("add_zero", 32'(zr), 32'd1);
    check("add_lat", 32'(lat), 32'd0);
    @(posedge clk); #1;
    check("add_in_ready_after", 32'(in_ready), 32'd1);
    check("add_out_valid_after", 32'(out_valid), 32'd0);

    run_op(4'b1010, 32'h8000_0000, 32'h24, 1'b1, res, zr, lat);
    check("ashr", res, 32'hF800_0000);
    run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 1'b1, res, zr, lat);
    check("less", res, 32'd1);
    check("less_zero", 32'(zr), 32'd0);
    run_op(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b1, res, zr, lat);
    check("and", res, 32'h00F0_1200);
    run_op(4'b0001, 32'hF000_0001, 32'h0000_0010, 1'b1, res, zr, lat);
    check("or", res, 32'hF000_0011);
    run_op(4'b1101, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b1, res, zr, lat);
    check("xor", res, 32'hF0F0_0F0F);
    run_op(4'b0110, 32'd5, 32'd7, 1'b1, res, zr, lat);
    check("sub", res, 32'hFFFF_FFFE);
    run_op(4'b1001, 32'd1, 32'h1F, 1'b1, res, zr, lat);
    check("shl", res, 32'h8000_0000);
    run_op(4'b1000, 32'h8000_0000, 32'd4, 1'b1, res, zr, lat);
    check("shr", res, 32'h0800_0000);
    run_op(4'b1111, 32'h1234, 32'h5678, 1'b1, res, zr, lat);
    check("unused_res", res, 32'd0);
    check("unused_zero", 32'(zr), 32'd1);
    check("unused_lat", 32'(lat), 32'd0);

    // Iterative ops
    run_op(4'b0011, 32'h1_0000, 32'h1_0000, 1'b1, res, zr, lat);
    check("mul_res", res, 32'd0);
    check("mul_zero", 32'(zr), 32'd1);
    check("mul_lat", 32'(lat), 32'd33);
    run_op(4'b0100, 32'h1_0000, 32'h1_0000, 1'b1, res, zr, lat);
    check("mulhu_res", res, 32'd1);
    check("mulhu_lat", 32'(lat), 32'd33);
    run_op(4'b0011, 32'd7, 32'd6, 1'b1, res, zr, lat);
    check("mul_small", res, 32'd42);
    run_op(4'b1100, 32'hFFFF_FFF9, 32'd2, 1'b1, res, zr, lat);
    check("div_neg", res, 32'hFFFF_FFFD);
    check("div_lat", 32'(lat), 32'd33);
    run_op(4'b1110, 32'hFFFF_FFF9, 32'd2, 1'b1, res, zr, lat);
    check("rem_neg", res, 32'hFFFF_FFFF);
    run_op(4'b0101, 32'd100, 32'd7, 1'b1, res, zr, lat);
    check("divu", res, 32'd14);
    run_op(4'b1011, 32'd100, 32'd7, 1'b1, res, zr, lat);
    check("remu", res, 32'd2);

    // Fast paths
    run_op(4'b0101, 32'd55, 32'd0, 1'b1, res, zr, lat);
    check("divu0_res", res, 32'hFFFF_FFFF);
    check("divu0_lat", 32'(lat), 32'd0);
    run_op(4'b1110, 32'hFFFF_FFF9, 32'd0, 1'b1, res, zr, lat);
    check("rem0_res", res, 32'hFFFF_FFF9);
    run_op(4'b1100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, res, zr, lat);
    check("div_ovf_res", res, 32'h8000_0000);
    check("div_ovf_lat", 32'(lat), 32'd0);
    run_op(4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, res, zr, lat);
    check("rem_ovf_res", res, 32'd0);
    check("rem_ovf_zero", 32'(zr), 32'd1);

    // Hold under backpressure; in_valid pulses must be ignored
    out_ready = 1'b0;
    run_op(4'b0010, 32'd3, 32'd4, 1'b0, res, zr, lat);
    check("hold_first", res, 32'd7);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0); alu_op = 4'b0110; op1 = 32'd100; op2 = 32'd1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", result, 32'd7);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);

    // Flush in the 5th BUSY cycle
    @(negedge clk);
    op1 = 32'd9; op2 = 32'd9; alu_op = 4'b0011; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("flush_no_valid", 32'(seen), 32'd0);
    check("flush_result_kept", result, 32'd7);

    // Async reset in the middle of BUSY
    @(negedge clk);
    op1 = 32'd1000; op2 = 32'd3; alu_op = 4'b0101; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("busy_rst_in_ready", 32'(in_ready), 32'd1);
    check("busy_rst_out_valid", 32'(out_valid), 32'd0);
    check("busy_rst_result", result, 32'd0);
    check("busy_rst_zero", 32'(zero), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("busy_rst_no_valid", 32'(seen), 32'd0);
    run_op(4'b0010, 32'd2, 32'd3, 1'b1, res, zr, lat);
    check("post_rst_add", res, 32'd5);
    check("post_rst_lat", 32'(lat), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
